// File: rtl/knight_rider_gen.sv
// knight_rider_gen
//   Sweeping-LED pattern generator feeding the ALU output mux (select 4'b1100).
//   A prescaler produces a step tick every (BASE_DIV >> rate) clocks. Each tick
//   moves a lit position one place along the word. The position bounces between
//   0 and WIDTH-1, and each end is shown for a single step. The output word is
//   built by an array of per-bit lanes.
//
// Ports
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   en        generator enable (select decode == 4'b1100)
//   mode      00 dot, 01 two-LED trail, 10 mirrored, 11 freeze
//   rate      step period = BASE_DIV >> rate clocks
//   nightrid  registered pattern word, one clock behind pos/prev
//   step      one-cycle pulse on each position advance
//   pos       current position (debug)

module knight_rider_lane #(
  parameter int WIDTH = 8,
  parameter int IDX   = 0,
  localparam int PW   = $clog2(WIDTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [1:0]    mode,
  input  logic [PW-1:0] pos,
  input  logic [PW-1:0] prev,
  output logic          q
);
  // The position that lights this bit directly, and its mirror image.
  localparam logic [PW-1:0] ME  = PW'(IDX);
  localparam logic [PW-1:0] MIR = PW'(WIDTH - 1 - IDX);

  logic hit_pos, hit_prev, hit_mir;

  assign hit_pos  = (pos  == ME);
  assign hit_prev = (prev == ME);
  assign hit_mir  = (pos  == MIR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 1'b0;
    end else if (!en) begin
      q <= 1'b0;
    end else begin
      unique case (mode)
        2'b00:   q <= hit_pos;
        2'b01:   q <= hit_pos | hit_prev;
        2'b10:   q <= hit_pos | hit_mir;
        default: q <= q;   // freeze: output holds
      endcase
    end
  end
endmodule

module knight_rider_gen #(
  parameter int WIDTH    = 8,
  parameter int BASE_DIV = 12500000,
  localparam int PW      = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [1:0]       rate,
  output logic [WIDTH-1:0] nightrid,
  output logic             step,
  output logic [PW-1:0]    pos
);
  localparam int CW = (BASE_DIV < 2) ? 1 : $clog2(BASE_DIV + 1);

  localparam logic [1:0]    MODE_FRZ = 2'b11;
  localparam logic [0:0]    DIR_UP   = 1'b0;
  localparam logic [0:0]    DIR_DN   = 1'b1;
  localparam logic [PW-1:0] POS_TOP  = PW'(WIDTH - 1);
  localparam logic [PW-1:0] POS_TOP1 = PW'(WIDTH - 2);
  localparam logic [PW-1:0] POS_ONE  = PW'(1);
  localparam logic [31:0]   BASE_U   = 32'(BASE_DIV);

  logic [CW-1:0] cnt;
  logic [31:0]   per;
  logic [31:0]   tc;
  logic          tick;
  logic          run;
  logic [0:0]    dir;
  logic [PW-1:0] prev;

  // Terminal count. It is clamped at 0 so that a very fast rate ticks on every clock.
  always_comb begin
    per = BASE_U >> rate;
    tc  = (per == 32'd0) ? 32'd0 : per - 32'd1;
  end

  assign run = en && (mode != MODE_FRZ);

  // The compare uses >= so that a rate change that drops TC below the running
  // count still ticks on the next cycle instead of wrapping the counter.
  assign tick = run && (32'(cnt) >= tc);

  // ---------------------------------------------------------------- prescaler
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!en) begin
      cnt <= '0;             // restart, so the first step is TC+1 clocks after en rises
    end else if (mode == MODE_FRZ) begin
      cnt <= cnt;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // ------------------------------------------------------------ sweep engine
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos  <= '0;
      prev <= '0;
      dir  <= DIR_UP;
      step <= 1'b0;
    end else begin
      step <= tick;
      if (tick) begin
        prev <= pos;
        unique case (dir)
          DIR_UP: begin
            if (pos == POS_TOP) begin
              dir <= DIR_DN;
              pos <= POS_TOP1;
            end else begin
              pos <= pos + 1'b1;
            end
          end
          default: begin
            if (pos == '0) begin
              dir <= DIR_UP;
              pos <= POS_ONE;
            end else begin
              pos <= pos - 1'b1;
            end
          end
        endcase
      end
    end
  end

  // -------------------------------------------------------- output lanes
  // Each lane registers its own bit from the current pos/prev, so the word
  // trails the position by exactly one clock.
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    knight_rider_lane #(
      .WIDTH (WIDTH),
      .IDX   (i)
    ) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .mode  (mode),
      .pos   (pos),
      .prev  (prev),
      .q     (nightrid[i])
    );
  end
endmodule

// File: tb/tb_knight_rider_gen.sv
module tb_knight_rider_gen;
  localparam int W  = 8;
  localparam int BD = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [1:0] rate = 2'b00;
  logic [7:0] nightrid;
  logic       step;
  logic [2:0] pos;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: the sweep is tracked as a number of steps taken since reset.
  int         m_cnt = 0;
  int         m_k   = 0;
  logic [7:0] m_nr  = 8'h00;
  bit         m_step = 1'b0;

  knight_rider_gen #(.WIDTH(W), .BASE_DIV(BD)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .mode     (mode),
    .rate     (rate),
    .nightrid (nightrid),
    .step     (step),
    .pos      (pos)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // The position after k steps, on the triangular path 0..W-1..0.
  function automatic int tri_pos(input int k);
    int m;
    m = k % (2 * (W - 1));
    return (m <= W - 1) ? m : 2 * (W - 1) - m;
  endfunction

  function automatic int m_tc(input logic [1:0] r);
    int p;
    p = BD >> r;
    return (p == 0) ? 0 : p - 1;
  endfunction

  function automatic logic [7:0] pat(input logic [1:0] md, input int p, input int q);
    logic [7:0] one;
    one = 8'h01;
    case (md)
      2'b00:   return one << p;
      2'b01:   return (one << p) | (one << q);
      default: return (one << p) | (one << (W - 1 - p));
    endcase
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_k = 0; m_nr = 8'h00; m_step = 1'b0;
  endtask

  // Advance one clock. The model sees the inputs present at the edge, and the
  // outputs are compared 1 time unit later.
  task automatic clk_cycle();
    bit tick;
    int p, q;
    @(posedge clk);
    p = tri_pos(m_k);
    q = (m_k == 0) ? 0 : tri_pos(m_k - 1);
    if (!en)               m_nr = 8'h00;
    else if (mode != 2'b11) m_nr = pat(mode, p, q);
    tick = en && (mode != 2'b11) && (m_cnt >= m_tc(rate));
    if (!en)                m_cnt = 0;
    else if (mode != 2'b11) m_cnt = tick ? 0 : m_cnt + 1;
    if (tick) m_k++;
    m_step = tick;
    #1;
    chk("nightrid", nightrid, m_nr);
    chk("pos", pos, tri_pos(m_k));
    chk("step", step, m_step);
  endtask

  // Called 1 unit after an edge. Reset is pulsed between edges and checked before any clock.
  task automatic mid_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_nightrid", nightrid, 0);
    chk("rst_pos", pos, 0);
    chk("rst_step", step, 0);
    model_reset();
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int lim, frz_pos;
    #3;
    chk("por_nightrid", nightrid, 0);
    chk("por_pos", pos, 0);
    chk("por_step", step, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();

    // Dot sweep at 4 clocks per step across several bounces.
    en = 1'b1; mode = 2'b00; rate = 2'd1;
    clk_cycle();
    chk("first_word", nightrid, 8'h01);
    for (int i = 0; i < 70; i++) clk_cycle();

    // Reset in the middle of a sweep.
    lim = 0;
    while (tri_pos(m_k) != 5 && lim < 100) begin clk_cycle(); lim++; end
    chk("reach_pos5", pos, 5);
    mid_reset();
    clk_cycle();
    chk("post_rst_word", nightrid, 8'h01);

    // Trail and mirror sweeps.
    mode = 2'b01;
    for (int i = 0; i < 64; i++) clk_cycle();
    mode = 2'b10;
    for (int i = 0; i < 64; i++) clk_cycle();

    // A rate change to a smaller TC while cnt is above it ticks on the next clock.
    mode = 2'b00; rate = 2'd0;
    lim = 0;
    while (m_cnt != 5 && lim < 20) begin clk_cycle(); lim++; end
    chk("cnt_at_5", m_cnt, 5);
    rate = 2'd2;
    clk_cycle();
    chk("rate_chg_step", step, 1);
    clk_cycle();
    clk_cycle();
    chk("rate2_step", step, 1);

    // Freeze for 50 clocks.
    mode = 2'b11;
    clk_cycle();
    frz_pos = pos;
    for (int i = 0; i < 50; i++) clk_cycle();
    chk("frozen_pos", pos, frz_pos);

    // Random segments of enable, mode and rate, with an occasional reset.
    for (int s = 0; s < 80; s++) begin
      en   = ($urandom_range(0, 5) != 0);
      mode = 2'($urandom_range(0, 3));
      rate = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) mid_reset();
      lim = $urandom_range(1, 30);
      for (int i = 0; i < lim; i++) clk_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
